// File: rtl/nios_sd_loader_tick_service.sv
// nios_sd_loader_tick_service
// Hardware client of the loader's interval timer. Programs the timer into
// continuous interrupt mode, acknowledges each timeout, keeps a 32-bit tick
// count and runs a 16-bit deadline down-counter for SD command/data timeouts.
//
// Optional build macro: TICK_SNAPSHOT_EN adds a timer snapshot read sequence
// whenever the deadline expires, exposed on snap_value/snap_valid.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   timer_irq             timer interrupt (level)
//   tm_*                  Avalon-MM master on the timer's 16-bit register port
//   stop_req, start_req   pulses: stop the timer / re-write the start control word
//   dl_start, dl_ticks    pulses: load deadline of dl_ticks ticks
//   dl_cancel             pulse: abort deadline
//   tick_count/tick_pulse ticks serviced since reset / one pulse per tick
//   dl_active/dl_expired  deadline running / sticky expiry flag
//   busy                  FSM outside IDLE
//   snap_value/snap_valid (TICK_SNAPSHOT_EN only) captured snapshot + strobe
//
// state  | meaning
// RST    | held in reset; leaves for INIT on the first clean edge
// INIT   | write control register with INIT_CTRL
// IDLE   | wait for stop/start request or timer irq
// STOP   | write control register with STOP_CTRL
// ACK    | write status register 0 to clear the timeout
// DROP   | absorb the timer's irq deassertion; tick is counted here
// SNAPW  | write snapl to latch the counter snapshot
// RDL    | read snapl
// RDH    | read snaph (snapl data arrives this cycle)
// CAPH   | snaph data arrives
// SVALID | snapshot strobe cycle
module nios_sd_loader_tick_service #(
    parameter logic [3:0] INIT_CTRL = 4'h7,
    parameter logic [3:0] STOP_CTRL = 4'h8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_irq,
    output logic [2:0]  tm_address,
    output logic        tm_chipselect,
    output logic        tm_write_n,
    output logic [15:0] tm_writedata,
    input  logic [15:0] tm_readdata,
    input  logic        stop_req,
    input  logic        start_req,
    input  logic        dl_start,
    input  logic [15:0] dl_ticks,
    input  logic        dl_cancel,
    output logic [31:0] tick_count,
    output logic        tick_pulse,
    output logic        dl_active,
    output logic        dl_expired,
    output logic        busy
`ifdef TICK_SNAPSHOT_EN
    ,
    output logic [31:0] snap_value,
    output logic        snap_valid
`endif
);

    typedef enum logic [3:0] {
        S_RST, S_INIT, S_IDLE, S_STOP, S_ACK, S_DROP
`ifdef TICK_SNAPSHOT_EN
        , S_SNAPW, S_RDL, S_RDH, S_CAPH, S_SVALID
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        stop_pend_q, stop_pend_d;
    logic        start_pend_q, start_pend_d;
    logic        stop_serve, start_serve;

    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wd_q, wd_d;
    logic        busy_q, busy_d;

    logic [31:0] tick_count_q;
    logic        tick_pulse_q;
    logic [15:0] dl_rem_q;
    logic        dl_active_q, dl_expired_q;

    logic        tick, last_tick;

    assign tick      = (state_q == S_DROP);
    assign last_tick = tick && dl_active_q && (dl_rem_q == 16'd1);

`ifdef TICK_SNAPSHOT_EN
    logic [31:0] snap_value_q;
    logic        snap_valid_q;
    logic        expire_now;
    // Expiry only happens if no deadline command overrides this tick.
    assign expire_now = last_tick && !dl_start && !dl_cancel;
`else
    logic unused_rd;
    assign unused_rd = ^tm_readdata;
`endif

    // state register and bus/output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RST;
            stop_pend_q  <= 1'b0;
            start_pend_q <= 1'b0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            addr_q       <= 3'd0;
            wd_q         <= 16'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            start_pend_q <= start_pend_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d     = state_q;
        stop_serve  = 1'b0;
        start_serve = 1'b0;
        case (state_q)
            S_RST:  state_d = S_INIT;
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (stop_req || stop_pend_q) begin
                    state_d    = S_STOP;
                    stop_serve = 1'b1;
                end else if (start_req || start_pend_q) begin
                    state_d     = S_INIT;
                    start_serve = 1'b1;
                end else if (timer_irq) begin
                    state_d = S_ACK;
                end
            end
            S_STOP: state_d = S_IDLE;
            S_ACK:  state_d = S_DROP;
`ifdef TICK_SNAPSHOT_EN
            S_DROP:   state_d = expire_now ? S_SNAPW : S_IDLE;
            S_SNAPW:  state_d = S_RDL;
            S_RDL:    state_d = S_RDH;
            S_RDH:    state_d = S_CAPH;
            S_CAPH:   state_d = S_SVALID;
            S_SVALID: state_d = S_IDLE;
`else
            S_DROP: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        // A request not served this cycle is held until IDLE can take it.
        stop_pend_d  = (stop_pend_q | stop_req) & ~stop_serve;
        start_pend_d = (start_pend_q | start_req) & ~start_serve;
    end

    // Bus outputs are decoded from the next state so the registered strobes
    // line up with the state the FSM is in.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'd0;
        busy_d = (state_d != S_IDLE) && (state_d != S_RST);
        case (state_d)
            S_INIT: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h0, INIT_CTRL};
            end
            S_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h0, STOP_CTRL};
            end
            S_ACK: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;
            end
`ifdef TICK_SNAPSHOT_EN
            S_SNAPW: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;
            end
            S_RDL: begin
                cs_d = 1'b1; addr_d = 3'd4;
            end
            S_RDH: begin
                cs_d = 1'b1; addr_d = 3'd5;
            end
`endif
            default: ;
        endcase
    end

    // tick counter and deadline
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count_q <= 32'd0;
            tick_pulse_q <= 1'b0;
            dl_rem_q     <= 16'd0;
            dl_active_q  <= 1'b0;
            dl_expired_q <= 1'b0;
        end else begin
            tick_pulse_q <= tick;
            if (tick) tick_count_q <= tick_count_q + 32'd1;
            if (dl_start) begin
                dl_rem_q     <= dl_ticks;
                dl_active_q  <= (dl_ticks != 16'd0);
                dl_expired_q <= (dl_ticks == 16'd0);
            end else if (dl_cancel) begin
                dl_active_q  <= 1'b0;
                dl_expired_q <= 1'b0;
            end else if (tick && dl_active_q) begin
                dl_rem_q <= dl_rem_q - 16'd1;
                if (last_tick) begin
                    dl_active_q  <= 1'b0;
                    dl_expired_q <= 1'b1;
                end
            end
        end
    end

`ifdef TICK_SNAPSHOT_EN
    // Read data is valid one cycle after its address, hence the offset capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= (state_q == S_CAPH);
            if (state_q == S_RDH)  snap_value_q[15:0]  <= tm_readdata;
            if (state_q == S_CAPH) snap_value_q[31:16] <= tm_readdata;
        end
    end
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
`endif

    assign tm_address    = addr_q;
    assign tm_chipselect = cs_q;
    assign tm_write_n    = wn_q;
    assign tm_writedata  = wd_q;
    assign busy          = busy_q;
    assign tick_count    = tick_count_q;
    assign tick_pulse    = tick_pulse_q;
    assign dl_active     = dl_active_q;
    assign dl_expired    = dl_expired_q;

endmodule

// File: tb/tb_nios_sd_loader_tick_service.sv
// Directed bench for nios_sd_loader_tick_service; expected values are
// hand-derived from the cycle timing of the block.
module tb_nios_sd_loader_tick_service;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_irq;
    logic [2:0]  tm_address;
    logic        tm_chipselect;
    logic        tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata;
    logic        stop_req, start_req;
    logic        dl_start, dl_cancel;
    logic [15:0] dl_ticks;
    logic [31:0] tick_count;
    logic        tick_pulse, dl_active, dl_expired, busy;
`ifdef TICK_SNAPSHOT_EN
    logic [31:0] snap_value;
    logic        snap_valid;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;

    nios_sd_loader_tick_service dut (
        .clk           (clk),
        .reset         (reset),
        .timer_irq     (timer_irq),
        .tm_address    (tm_address),
        .tm_chipselect (tm_chipselect),
        .tm_write_n    (tm_write_n),
        .tm_writedata  (tm_writedata),
        .tm_readdata   (tm_readdata),
        .stop_req      (stop_req),
        .start_req     (start_req),
        .dl_start      (dl_start),
        .dl_ticks      (dl_ticks),
        .dl_cancel     (dl_cancel),
        .tick_count    (tick_count),
        .tick_pulse    (tick_pulse),
        .dl_active     (dl_active),
        .dl_expired    (dl_expired),
        .busy          (busy)
`ifdef TICK_SNAPSHOT_EN
        ,
        .snap_value    (snap_value),
        .snap_valid    (snap_valid)
`endif
    );

    always #5 clk = ~clk;

    // timer register port model: read data one cycle after the address
    always @(posedge clk) begin
        if (tm_chipselect && tm_write_n)
            tm_readdata <= (tm_address == 3'd4) ? 16'h1234 :
                           (tm_address == 3'd5) ? 16'h0056 : 16'hDEAD;
        else
            tm_readdata <= 16'h0000;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
        chk({tag, "_cs"},   tm_chipselect, 1);
        chk({tag, "_wn"},   tm_write_n,    0);
        chk({tag, "_addr"}, tm_address,    a);
        chk({tag, "_data"}, tm_writedata,  d);
        chk({tag, "_busy"}, busy,          1);
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_cs"},   tm_chipselect, 0);
        chk({tag, "_wn"},   tm_write_n,    1);
        chk({tag, "_addr"}, tm_address,    0);
        chk({tag, "_data"}, tm_writedata,  0);
    endtask

    // Raise irq, expect ACK one cycle later, tick two cycles after that
    // sample. Optionally issue dl_start in the DROP cycle.
    task automatic do_irq(input bit ld_in_drop, input logic [15:0] ld_val);
        timer_irq = 1'b1;
        @(negedge clk);
        chk_wr("ack", 3'd0, 16'h0000);
        chk("ack_pulse", tick_pulse, 0);
        timer_irq = 1'b0;
        @(negedge clk);
        chk("drop_pulse", tick_pulse, 0);
        chk("drop_busy", busy, 1);
        chk("drop_cs", tm_chipselect, 0);
        if (ld_in_drop) begin
            dl_start = 1'b1;
            dl_ticks = ld_val;
        end
        @(negedge clk);
        dl_start = 1'b0;
        exp_cnt  = exp_cnt + 32'd1;
        chk("tick_pulse", tick_pulse, 1);
        chk("tick_count", tick_count, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; timer_irq = 1'b0; stop_req = 1'b0; start_req = 1'b0;
        dl_start = 1'b0; dl_cancel = 1'b0; dl_ticks = 16'd0;
        repeat (3) @(negedge clk);
        chk_bus_idle("rst");
        chk("rst_busy", busy, 0);
        chk("rst_count", tick_count, 0);
        chk("rst_dl", {dl_active, dl_expired, tick_pulse}, 0);

        // start-up programming
        reset = 1'b0;
        @(negedge clk);
        chk_wr("init", 3'd1, 16'h0007);
        @(negedge clk);
        chk_bus_idle("post_init");
        chk("post_init_busy", busy, 0);

        // three serviced ticks
        for (int i = 0; i < 3; i++) do_irq(1'b0, 16'd0);
        chk("three_ticks", tick_count, 3);
        @(negedge clk);
        chk("pulse_one_cycle", tick_pulse, 0);

        // start_req re-runs INIT
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk_wr("restart", 3'd1, 16'h0007);
        @(negedge clk);
        chk("restart_done", busy, 0);

        // deadline of 2 ticks
        dl_start = 1'b1; dl_ticks = 16'd2;
        @(negedge clk);
        dl_start = 1'b0;
        chk("dl2_load", {dl_active, dl_expired}, 2'b10);
        do_irq(1'b0, 16'd0);
        chk("dl2_tick1", {dl_active, dl_expired}, 2'b10);
        do_irq(1'b0, 16'd0);
        chk("dl2_tick2", {dl_active, dl_expired}, 2'b01);
        repeat (6) @(negedge clk);
        chk("dl2_sticky", dl_expired, 1);

        // cancel clears, zero-length deadline expires at once
        dl_cancel = 1'b1;
        @(negedge clk);
        dl_cancel = 1'b0;
        chk("cancel", {dl_active, dl_expired}, 2'b00);
        dl_start = 1'b1; dl_ticks = 16'd0;
        @(negedge clk);
        dl_start = 1'b0;
        chk("dl0", {dl_active, dl_expired}, 2'b01);

        // start and cancel together: start wins
        dl_start = 1'b1; dl_cancel = 1'b1; dl_ticks = 16'd5;
        @(negedge clk);
        dl_start = 1'b0; dl_cancel = 1'b0;
        chk("start_beats_cancel", {dl_active, dl_expired}, 2'b10);

        // reload coinciding with a tick: load wins, no decrement
        do_irq(1'b1, 16'd3);
        chk("reload_tick", {dl_active, dl_expired}, 2'b10);
        do_irq(1'b0, 16'd0);
        do_irq(1'b0, 16'd0);
        chk("reload_2left", {dl_active, dl_expired}, 2'b10);
        do_irq(1'b0, 16'd0);
        chk("reload_exp", {dl_active, dl_expired}, 2'b01);
        repeat (6) @(negedge clk);
        dl_cancel = 1'b1;
        @(negedge clk);
        dl_cancel = 1'b0;

        // tick counter wrap
        force dut.tick_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.tick_count_q;
        @(negedge clk);
        chk("preset_count", tick_count, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        do_irq(1'b0, 16'd0);
        chk("wrap_count", tick_count, 0);
        chk("wrap_dl", {dl_active, dl_expired}, 2'b00);
        @(negedge clk);
        chk("wrap_idle", busy, 0);

        // stop_req during ACK, then reset during the STOP write
        timer_irq = 1'b1;
        @(negedge clk);
        chk_wr("ack2", 3'd0, 16'h0000);
        timer_irq = 1'b0;
        stop_req  = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        chk("stop_drop_cs", tm_chipselect, 0);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        chk("stop_tick", tick_pulse, 1);
        chk("stop_count", tick_count, exp_cnt);
        @(negedge clk);
        chk_wr("stop", 3'd1, 16'h0008);
        start_req = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk_bus_idle("rst2");
        chk("rst2_busy", busy, 0);
        chk("rst2_count", tick_count, 0);
        exp_cnt = 32'd0;
        reset = 1'b0;
        @(negedge clk);
        chk_wr("reinit", 3'd1, 16'h0007);
        @(negedge clk);
        chk_bus_idle("reinit_done");
        chk("reinit_busy", busy, 0);

`ifdef TICK_SNAPSHOT_EN
        // snapshot sequence on deadline expiry
        dl_start = 1'b1; dl_ticks = 16'd1;
        @(negedge clk);
        dl_start = 1'b0;
        do_irq(1'b0, 16'd0);
        chk("snap_exp", dl_expired, 1);
        chk_wr("snapw", 3'd4, 16'h0000);
        @(negedge clk);
        chk("rdl_cs", tm_chipselect, 1);
        chk("rdl_wn", tm_write_n, 1);
        chk("rdl_addr", tm_address, 4);
        chk("rdl_busy", busy, 1);
        @(negedge clk);
        chk("rdh_cs", tm_chipselect, 1);
        chk("rdh_wn", tm_write_n, 1);
        chk("rdh_addr", tm_address, 5);
        chk("rdh_busy", busy, 1);
        @(negedge clk);
        chk("caph_cs", tm_chipselect, 0);
        chk("caph_busy", busy, 1);
        chk("caph_valid", snap_valid, 0);
        @(negedge clk);
        chk("snap_valid", snap_valid, 1);
        chk("snap_value", snap_value, 32'h0056_1234);
        chk("svalid_busy", busy, 1);
        @(negedge clk);
        chk("snap_valid_drop", snap_valid, 0);
        chk("snap_busy_drop", busy, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
